// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, state encodings and GF(2^8) helpers
//
// Purpose: items shared by the AES key schedule and the cipher datapath.
//   AES_NUM_ROUNDS  final round-key index for AES-128
//   AES_RCON_INIT   first round constant
//   AES_RCON_POLY   reduction byte of the AES field polynomial x^8+x^4+x^3+x+1
//   aes_ks_state_e  key-schedule FSM encodings (IDLE / EMIT)
//   xtime()         multiply by x in GF(2^8); also used by MixColumns
package aes_pkg;

  localparam int         AES_NUM_ROUNDS = 10;
  localparam logic [7:0] AES_RCON_INIT  = 8'h01;
  localparam logic [7:0] AES_RCON_POLY  = 8'h1b;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } aes_ks_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? AES_RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box
//
// Purpose: 8-bit forward substitution, shared with the cipher datapath.
// Ports:
//   x  input  8  byte to substitute
//   y  output 8  S-box(x)
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  // Row 0 sits in the most significant bits, so entry x lives at
  // bit offset 8*(255-x).
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TABLE[8*(255 - int'(x)) +: 8];

endmodule

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - iterative AES-128 key schedule with valid/ready round-key stream
//
// Purpose: accepts a cipher key and emits round keys 0..NUM_ROUNDS in order,
// one per rk_valid_o/rk_ready_i handshake, computing each next key with one
// combinational expansion stage on the registered key.
// Ports:
//   clk_i        input   1      clock, rising edge
//   rst_i        input   1      asynchronous active-high reset
//   key_i        input   WIDTH  cipher key, sampled on key handshake
//   key_valid_i  input   1      key_i valid
//   key_ready_o  output  1      ready for a key (IDLE)
//   rk_o         output  WIDTH  current round key, word 0 in [127:96]
//   rk_round_o   output  4      index of rk_o
//   rk_last_o    output  1      final round key presented
//   rk_valid_o   output  1      round-key outputs valid
//   rk_ready_i   input   1      consumer accepts round key
//   busy_o       output  1      sequence in progress (EMIT)
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int WIDTH      = 128,
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] key_i,
  input  logic             key_valid_i,
  output logic             key_ready_o,
  output logic [WIDTH-1:0] rk_o,
  output logic [3:0]       rk_round_o,
  output logic             rk_last_o,
  output logic             rk_valid_o,
  input  logic             rk_ready_i,
  output logic             busy_o
);

  aes_ks_state_e    state_q, state_d;
  logic [WIDTH-1:0] rk_q, rk_d;
  logic [3:0]       round_q, round_d;
  logic [7:0]       rcon_q, rcon_d;

  logic             at_last;
  logic [31:0]      w0, w1, w2, w3;
  logic [31:0]      rot_w3, sub_w3, t_word;
  logic [31:0]      n0, n1, n2, n3;
  logic [WIDTH-1:0] rk_next;

  assign at_last = (round_q == 4'(NUM_ROUNDS));

  // Expansion: RotWord, SubWord, rcon injection, then the word XOR chain.
  assign {w0, w1, w2, w3} = rk_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .x (rot_w3[8*i +: 8]),
      .y (sub_w3[8*i +: 8])
    );
  end

  assign t_word  = sub_w3 ^ {rcon_q, 24'h0};
  assign n0      = w0 ^ t_word;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rk_q    <= '0;
      round_q <= '0;
      rcon_q  <= AES_RCON_INIT;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  // Without a handshake every register holds, which keeps the outputs
  // stable while the consumer back-pressures.
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    case (state_q)
      ST_IDLE: begin
        if (key_valid_i) begin
          rk_d    = key_i;
          round_d = '0;
          rcon_d  = AES_RCON_INIT;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (rk_ready_i) begin
          if (at_last) begin
            state_d = ST_IDLE;
          end else begin
            rk_d    = rk_next;
            round_d = round_q + 4'd1;
            rcon_d  = xtime(rcon_q);
          end
        end
      end
    endcase
  end

  assign key_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q == ST_EMIT);
  assign rk_valid_o  = (state_q == ST_EMIT);
  assign rk_last_o   = (state_q == ST_EMIT) && at_last;
  assign rk_o        = rk_q;
  assign rk_round_o  = round_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - directed self-checking bench for aes_key_schedule
module tb_aes_key_schedule;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [127:0] key_i = '0;
  logic         key_valid_i = 1'b0;
  logic         key_ready_o;
  logic [127:0] rk_o;
  logic [3:0]   rk_round_o;
  logic         rk_last_o;
  logic         rk_valid_o;
  logic         rk_ready_i = 1'b0;
  logic         busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] fips_rk [0:10];
  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] OTHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_schedule #(
    .WIDTH      (128),
    .NUM_ROUNDS (10)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .key_i       (key_i),
    .key_valid_i (key_valid_i),
    .key_ready_o (key_ready_o),
    .rk_o        (rk_o),
    .rk_round_o  (rk_round_o),
    .rk_last_o   (rk_last_o),
    .rk_valid_o  (rk_valid_o),
    .rk_ready_i  (rk_ready_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Returns in the cycle right after the accepting edge (round 0 presented).
  task automatic offer_key(input logic [127:0] k, input string tag);
    int t;
    t = 0;
    key_i = k;
    key_valid_i = 1'b1;
    while (!key_ready_o && t < 50) begin
      tick();
      t++;
    end
    check({tag, "_key_ready_wait"}, 128'(key_ready_o), 128'(1'b1));
    tick();
    key_valid_i = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"},     128'(rk_valid_o),  128'(1'b0));
    check({tag, "_rk"},        rk_o,              128'h0);
    check({tag, "_round"},     128'(rk_round_o),  128'(4'd0));
    check({tag, "_last"},      128'(rk_last_o),   128'(1'b0));
    check({tag, "_busy"},      128'(busy_o),      128'(1'b0));
    check({tag, "_key_ready"}, 128'(key_ready_o), 128'(1'b1));
  endtask

  initial begin
    int idx;
    int cyc;
    bit rdy;
    bit stalled;
    logic [127:0] prev_rk;
    logic [3:0]   prev_round;

    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Reset state, with rk_ready_i high in IDLE to show it is ignored.
    #3;
    check_idle_outputs("reset");
    rk_ready_i = 1'b1;
    tick();
    tick();
    #3;
    rst_i = 1'b0;
    tick();
    check("idle_ready_ignored", 128'(rk_valid_o), 128'(1'b0));

    // FIPS-197 key with rk_ready_i held high, full stream and timing.
    offer_key(FIPS_KEY, "fips");
    for (int r = 0; r <= 10; r++) begin
      check($sformatf("fips_valid_r%0d", r), 128'(rk_valid_o),  128'(1'b1));
      check($sformatf("fips_round_r%0d", r), 128'(rk_round_o),  128'(r));
      check($sformatf("fips_rk_r%0d", r),    rk_o,              fips_rk[r]);
      check($sformatf("fips_last_r%0d", r),  128'(rk_last_o),   128'(r == 10));
      check($sformatf("fips_busy_r%0d", r),  128'(busy_o),      128'(1'b1));
      check($sformatf("fips_kr_r%0d", r),    128'(key_ready_o), 128'(1'b0));
      tick();
    end
    check("fips_key_ready_n12", 128'(key_ready_o), 128'(1'b1));
    check("fips_valid_n12",     128'(rk_valid_o),  128'(1'b0));
    check("fips_busy_n12",      128'(busy_o),      128'(1'b0));

    // A different key offered at round 4 must be ignored.
    offer_key(FIPS_KEY, "emitkey");
    for (int r = 0; r <= 10; r++) begin
      check($sformatf("emitkey_round_r%0d", r), 128'(rk_round_o),  128'(r));
      check($sformatf("emitkey_rk_r%0d", r),    rk_o,              fips_rk[r]);
      check($sformatf("emitkey_kr_r%0d", r),    128'(key_ready_o), 128'(1'b0));
      if (r == 4) begin
        key_i = OTHER_KEY;
        key_valid_i = 1'b1;
      end
      if (r == 10) key_valid_i = 1'b0;
      tick();
    end
    check("emitkey_done_valid", 128'(rk_valid_o), 128'(1'b0));
    tick();
    check("emitkey_not_taken", 128'(rk_valid_o), 128'(1'b0));

    // Backpressure: random ready with forced 5-cycle low stretches.
    rk_ready_i = 1'b0;
    offer_key(FIPS_KEY, "bp");
    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    prev_rk = '0;
    prev_round = '0;
    while (idx < 11 && cyc < 300) begin
      check($sformatf("bp_valid_c%0d", cyc), 128'(rk_valid_o), 128'(1'b1));
      check($sformatf("bp_round_c%0d", cyc), 128'(rk_round_o), 128'(idx));
      check($sformatf("bp_rk_c%0d", cyc),    rk_o,             fips_rk[idx]);
      check($sformatf("bp_last_c%0d", cyc),  128'(rk_last_o),  128'(idx == 10));
      if (stalled) begin
        check($sformatf("bp_stable_rk_c%0d", cyc),    rk_o,             prev_rk);
        check($sformatf("bp_stable_round_c%0d", cyc), 128'(rk_round_o), 128'(prev_round));
      end
      if ((cyc % 16) >= 3 && (cyc % 16) <= 7) rdy = 1'b0;
      else rdy = 1'($urandom_range(0, 1));
      rk_ready_i = rdy;
      prev_rk = rk_o;
      prev_round = rk_round_o;
      stalled = !rdy;
      tick();
      cyc++;
      if (rdy) idx++;
    end
    check("bp_all_rounds", 128'(idx), 128'(11));
    check("bp_end_valid", 128'(rk_valid_o), 128'(1'b0));

    // Reset at round 6, then a new key right after release.
    rk_ready_i = 1'b1;
    offer_key(FIPS_KEY, "rst");
    for (int r = 0; r < 6; r++) tick();
    check("rst_at_round6", 128'(rk_round_o), 128'(4'd6));
    #2;
    rst_i = 1'b1;
    #1;
    check_idle_outputs("rst_async");
    @(posedge clk_i);
    #4;
    check_idle_outputs("rst_held");
    rst_i = 1'b0;
    key_i = '0;
    key_valid_i = 1'b1;
    tick();
    key_valid_i = 1'b0;
    check("zero_first_edge_valid", 128'(rk_valid_o), 128'(1'b1));
    for (int r = 0; r <= 10; r++) begin
      check($sformatf("zero_round_r%0d", r), 128'(rk_round_o), 128'(r));
      check($sformatf("zero_last_r%0d", r),  128'(rk_last_o),  128'(r == 10));
      if (r == 0)  check("zero_rk_r0",  rk_o, 128'h0);
      if (r == 1)  check("zero_rk_r1",  rk_o, ZERO_R1);
      if (r == 10) check("zero_rk_r10", rk_o, ZERO_R10);
      tick();
    end
    check("zero_end_key_ready", 128'(key_ready_o), 128'(1'b1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative AES-128 key-schedule sequencer that accepts a cipher key and streams out all eleven round keys (round 0 through round 10) in order, one per output handshake. It sits directly upstream of the round-datapath key input. It replaces a fixed feedback loop with a registered key plus an on-chip rcon generator, and it adds valid/ready flow control so the datapath can stall the schedule.

## Interface
- WIDTH, 128, key and round-key width in bits; only 128 is supported.
- NUM_ROUNDS, 10, index of the final round key emitted.
- clk_i  input  1  single clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- key_i  input  WIDTH  cipher key; sampled only on the key handshake.
- key_valid_i  input  1  key_i is valid.
- key_ready_o  output  1  block can accept a key; high only in IDLE.
- rk_o  output  WIDTH  current round key; word 0 is in [127:96].
- rk_round_o  output  4  index of rk_o, 0..NUM_ROUNDS.
- rk_last_o  output  1  high when rk_round_o == NUM_ROUNDS and rk_valid_o is high.
- rk_valid_o  output  1  rk_o, rk_round_o and rk_last_o are valid.
- rk_ready_i  input  1  consumer accepts the round key this cycle.
- busy_o  output  1  high in EMIT.

## Operation
- Two states, IDLE and EMIT.
- Registers: rk_q (128 bits), round_q (4 bits), rcon_q (8 bits), state_q.
- IDLE:
  - key_ready_o = 1, rk_valid_o = 0.
  - On key_valid_i & key_ready_o: rk_q <= key_i, round_q <= 0, rcon_q <= 8'h01, state <= EMIT.
- EMIT:
  - rk_valid_o = 1; rk_o = rk_q; rk_round_o = round_q.
  - Handshake with round_q == NUM_ROUNDS: state <= IDLE. rk_q is held, but its value is don't-care.
  - Handshake with round_q < NUM_ROUNDS: rk_q <= expand(rk_q, rcon_q), round_q <= round_q + 1, rcon_q <= xtime(rcon_q).
  - No handshake: all registers hold, so outputs stay stable under backpressure.
- expand(k, rc), with w0..w3 = k[127:96], k[95:64], k[63:32], k[31:0]:
  - t = SubWord(RotWord(w3)) ^ {rc, 24'h0}, where RotWord({a,b,c,d}) = {b,c,d,a}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2; result is {n0,n1,n2,n3}.
- xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1b : 8'h00).
  - Consumed rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - One further update after round 9 is discarded.
- key_valid_i while in EMIT is ignored; key_i is not sampled.
- rk_ready_i while in IDLE is ignored.
- busy_o = (state_q == EMIT).

## Timing
- Reset (asynchronous assert, registers cleared immediately):
  - state IDLE, rk_q = 0, round_q = 0, rcon_q = 8'h01.
  - rk_valid_o = 0, rk_o = 0, rk_round_o = 0, rk_last_o = 0, busy_o = 0, key_ready_o = 1.
- Reset asserted mid-EMIT aborts the sequence. No partial round key is presented after release.
- Deassertion is used synchronously to clk_i. The first key can be accepted on the first rising edge after release.
- Key accepted on edge N: round 0 is presented in cycle N+1.
- With rk_ready_i held high, round r is presented in cycle N+1+r, and the last handshake occurs in cycle N+11.
- key_ready_o is high again in cycle N+12, so back-to-back keys have a 12-cycle minimum period.
- Expansion is one combinational stage: four S-boxes plus an XOR chain. It lies between rk_q and rk_q's input, with nothing on the output path.
- rk_o and rk_round_o are direct register outputs. rk_last_o and rk_valid_o are decoded from registers only.

## Structure
- Shared package aes_pkg holds:
  - AES_NUM_ROUNDS = 10
  - AES_RCON_INIT = 8'h01
  - AES_RCON_POLY = 8'h1b
  - IDLE/EMIT state encodings
  - the xtime function, reused by MixColumns
- Sub-module aes_sbox: combinational 8-bit forward S-box, instantiated four times for SubWord. It is the same table the cipher datapath uses, so it is shared rather than duplicated as a function.
- Top level contains the FSM, the rk_q/round_q/rcon_q registers and the XOR chain. Target size is about 150 lines plus aes_sbox.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready_i held high:
  - round 0 equals the key
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with rk_last_o = 1
  - key_ready_o high in cycle N+12
- All-zero key:
  - round 1 = 62636363626363636263636362636363
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e
- Backpressure: toggle rk_ready_i randomly, including 5-cycle low stretches. rk_o and rk_round_o must stay stable while valid is high and ready is low. The same 11 keys appear in order, with no skipped or repeated round.
- Key offered in EMIT: assert key_valid_i with a different key at round 4. key_ready_o stays 0 and the current sequence completes unchanged.
- Reset mid-sequence: assert rst_i at round 6. Outputs go to reset values immediately. After release, a new key yields round 1 with rcon 01, i.e. its correct round 1.
